apb_master: RTL and testbench

APB requester that drives the pbslave bus from a simple valid/ready command port. It accepts one command, runs a SETUP then ACCESS phase, and waits on pready. It then returns read data or completion on a valid/ready response port. It sits directly upstream of pbslave and replaces the testbench driver in system builds.

---
 rtl/pb_pkg.sv | 25 ++
 rtl/apb_wait_timer.sv | 38 +++
 rtl/apb_master.sv | 169 ++++++++++++++++
 tb/tb_apb_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared types for the pbslave subsystem: APB phase encoding, default bus
// widths, and packed request/response records for benches and system wrappers.
package pb_pkg;

    localparam int PB_ADDR_W = 8;
    localparam int PB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                 write;
        logic [PB_ADDR_W-1:0] addr;
        logic [PB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [PB_DATA_W-1:0] rdata;
        logic                 err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter for apb_master: cleared by clr, advanced by en,
// hit flags the enabled cycle that brings the count to LIMIT (APB_TIMEOUT_EN).
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The LIMIT-th stalled cycle is the one where LIMIT-1 stalls already counted.
    assign hit = en && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: valid/ready command in, SETUP/ACCESS bus cycle, valid/ready response out.
// Define APB_TIMEOUT_EN to abort ACCESS with rsp_err after TIMEOUT_CYC stalled cycles.
module apb_master
    import pb_pkg::*;
#(
    parameter int ADDR_W      = PB_ADDR_W,
    parameter int DATA_W      = PB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_SETUP  = 2'(SETUP);
    localparam logic [1:0] S_ACCESS = 2'(ACCESS);

    logic [1:0]        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              accept;

`ifdef APB_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    logic tmo_hit;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk (pclk),
        .rst (preset),
        .clr (state_q == S_SETUP),
        .en  ((state_q == S_ACCESS) && !pready),
        .hit (tmo_hit)
    );
`endif

    // Only one transaction in flight: a held response blocks new commands.
    assign req_ready = (state_q == S_IDLE) && !rsp_valid_q;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = S_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_IDLE;
                end
`endif
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small memory-backed APB slave model.
`timescale 1ns/1ps
module tb_apb_master;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    apb_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    // Slave model: inserts slave_ws wait states per ACCESS, stores writes.
    int unsigned slave_ws;
    logic        pready_stuck;
    int unsigned wait_cnt;
    logic [31:0] mem [int];

    assign pready = !pready_stuck && (wait_cnt >= slave_ws);

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= 0;
            prdata   <= '0;
        end else if (psel && !penable) begin
            wait_cnt <= 0;
            prdata   <= mem.exists(int'(paddr)) ? mem[int'(paddr)] : 32'h0;
        end else if (psel && penable) begin
            if (pready) begin
                wait_cnt <= 0;
                if (pwrite) mem[int'(paddr)] = pwdata;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one command at a negedge with rsp_ready=1 and checks the whole
    // bus cycle; returns at the negedge after the response is consumed.
    task automatic run_cmd(input string tag, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input int ws,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        int en_cyc;
        int unstable;
        slave_ws = ws;
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge pclk);
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
        lat = 1;
        check({tag, "_setup_sel_en"}, 32'({psel, penable}), 32'b10);
        check({tag, "_setup_addr"}, 32'(paddr), 32'(a));
        check({tag, "_setup_wdata"}, pwdata, d);
        check({tag, "_setup_write"}, 32'(pwrite), 32'(w));
        en_cyc   = 0;
        unstable = 0;
        while (!rsp_valid && lat < 60) begin
            @(negedge pclk);
            lat++;
            if (psel && penable) en_cyc++;
            if (!rsp_valid && (!psel || !penable || paddr !== a || pwdata !== d || pwrite !== w))
                unstable++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_penable_cycles"}, 32'(en_cyc), 32'(exp_lat - 2));
        check({tag, "_bus_stable"}, 32'(unstable), 32'd0);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_bus_idle"}, 32'({psel, penable}), 32'b00);
        check({tag, "_addr_hold"}, 32'(paddr), 32'(a));
        @(negedge pclk);
        check({tag, "_rsp_consumed"}, 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          ws;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        vecs[0] = '{1'b1, 8'h04, 32'hDEADBEEF, 0, 32'h00000000, 3};
        vecs[1] = '{1'b0, 8'h04, 32'h00000000, 0, 32'hDEADBEEF, 3};
        vecs[2] = '{1'b1, 8'h10, 32'h12345678, 3, 32'h00000000, 6};
        vecs[3] = '{1'b0, 8'h10, 32'h00000000, 1, 32'h12345678, 4};
        vecs[4] = '{1'b0, 8'h20, 32'h00000000, 0, 32'h00000000, 3};
        vecs[5] = '{1'b1, 8'hFF, 32'hA5A5A5A5, 2, 32'h00000000, 5};
        vecs[6] = '{1'b0, 8'hFF, 32'h00000000, 0, 32'hA5A5A5A5, 3};
        vecs[7] = '{1'b0, 8'h04, 32'h00000000, 2, 32'hDEADBEEF, 5};

        preset       = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        pready_stuck = 1'b0;
        slave_ws     = 0;
        repeat (3) @(negedge pclk);

        check("reset_ctrl", 32'({psel, penable, pwrite, rsp_valid, rsp_err}), 32'd0);
        check("reset_paddr", 32'(paddr), 32'd0);
        check("reset_pwdata", pwdata, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        preset = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("v%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                    vecs[i].ws, vecs[i].exp_rdata, 1'b0, vecs[i].exp_lat);
        end

        // Response backpressure with a second command already waiting.
        slave_ws  = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h30;
        req_wdata = 32'h11112222;
        @(negedge pclk);
        req_write = 1'b0;
        req_wdata = 32'h0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge pclk);
            n++;
        end
        check("bp_first_rsp_cycle", 32'(n), 32'd2);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (req_ready || psel || !rsp_valid) bad++;
            @(negedge pclk);
        end
        check("bp_blocked", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(negedge pclk);
        check("bp_after_hs", 32'({rsp_valid, req_ready, psel}), 32'b010);
        @(negedge pclk);
        req_valid = 1'b0;
        check("bp_second_psel", 32'({psel, penable}), 32'b10);
        check("bp_second_addr", 32'({pwrite, paddr}), 32'({1'b0, 8'h30}));
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge pclk);
            n++;
        end
        check("bp_second_rdata", rsp_rdata, 32'h11112222);
        @(negedge pclk);

        // Reset pulse in the middle of a stalled read.
        slave_ws  = 6;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h04;
        @(negedge pclk);
        req_valid = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_mid_access", 32'({psel, penable}), 32'b11);
        #2 preset = 1'b1;
        #1;
        check("rst_async_drop", 32'({psel, penable, rsp_valid}), 32'b000);
        @(negedge pclk);
        preset = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge pclk);
            if (rsp_valid || psel) bad++;
        end
        check("rst_no_response", 32'(bad), 32'd0);
        run_cmd("post_rst", 1'b0, 8'h04, 32'h0, 0, 32'hDEADBEEF, 1'b0, 3);

`ifdef APB_TIMEOUT_EN
        pready_stuck = 1'b1;
        run_cmd("tmo_stuck", 1'b0, 8'h04, 32'h0, 0, 32'h0, 1'b1, TIMEOUT_CYC + 2);
        pready_stuck = 1'b0;
        run_cmd("tmo_edge", 1'b0, 8'h04, 32'h0, TIMEOUT_CYC - 1, 32'hDEADBEEF, 1'b0, TIMEOUT_CYC + 2);
`else
        run_cmd("long_wait", 1'b0, 8'h10, 32'h0, 20, 32'h12345678, 1'b0, 23);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
